// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero and signed-overflow results returned without iterating.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [TAGW-1:0] req_tag,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [TAGW-1:0] resp_tag
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     res_q, res_d;

  // Request decode: operand magnitudes, result sign and special-case result.
  logic            a_sgn_op, b_sgn_op, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    a_sgn_op = (req_op == 3'b001) || (req_op == 3'b010) || (req_op == 3'b100) ||
               (req_op == 3'b110);
    b_sgn_op = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
    a_neg    = a_sgn_op & req_a[XLEN-1];
    b_neg    = b_sgn_op & req_b[XLEN-1];
    a_mag    = a_neg ? -req_a : req_a;
    b_mag    = b_neg ? -req_b : req_b;
    div_zero = req_op[2] && (req_b == '0);
    div_ovf  = req_op[2] && !req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (req_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = req_op[1] ? req_a : '1;
    else          spec_res = req_op[1] ? '0 : req_a;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod_fin;
  logic [XLEN-1:0]   div_sel, div_fin, res_fin;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, mcand_q};
    if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    step     = op_q[2] ? div_next : mul_next;
    prod_fin = neg_q ? -step : step;
    div_sel  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    div_fin  = neg_q ? -div_sel : div_sel;
    if (op_q[2])              res_fin = div_fin;
    else if (op_q[1:0] == '0) res_fin = prod_fin[XLEN-1:0];
    else                      res_fin = prod_fin[2*XLEN-1:XLEN];
  end

  assign req_ready  = (state_q == StIdle) && !flush && !reset;
  assign resp_valid = (state_q == StDone);
  assign resp_data  = resp_valid ? res_q : '0;
  assign resp_tag   = resp_valid ? tag_q : '0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          tag_d   = req_tag;
          mcand_d = b_mag;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          neg_d   = (req_op == 3'b110) ? a_neg : (a_neg ^ b_neg);
          cnt_d   = '0;
          if (special) begin
            res_d   = spec_res;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          res_d   = res_fin;
          state_d = StDone;
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      tag_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(32), .TAGW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request and returns right after the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input string name);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    check({name, "_req_ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for resp_valid; latency n counts the first negedge after accept as 1.
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int lat, input logic [31:0] exp,
                        input string name);
    int n;
    start_op(op, a, b, tag, name);
    wait_resp(n);
    check({name, "_latency"}, n, lat);
    check({name, "_data"}, resp_data, exp);
    check({name, "_tag"}, resp_tag, tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic expect_silence(input string name);
    int hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) hits++;
    end
    check({name, "_no_resp"}, hits, 0);
  endtask

  initial begin
    int n;
    logic [31:0] held_data;
    logic [4:0]  held_tag;
    int bad;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_tag", resp_tag, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    run_op(3'b000, 32'h7,        32'hFFFF_FFFD, 5'd3,  33, 32'hFFFF_FFEB, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 33, 32'h4000_0000, "mulh");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 33, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 33, 32'hFFFF_FFFE, "mulhu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'h2,         5'd7, 33, 32'hFFFF_FFFD, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2,         5'd8, 33, 32'hFFFF_FFFF, "rem");
    run_op(3'b101, 32'd100,       32'd7,         5'd9, 33, 32'd14,        "divu");
    run_op(3'b111, 32'd100,       32'd7,         5'd10, 33, 32'd2,        "remu");
    run_op(3'b101, 32'd5,         32'd0,         5'd11, 1, 32'hFFFF_FFFF, "divu_by0");
    run_op(3'b111, 32'd5,         32'd0,         5'd12, 1, 32'd5,         "remu_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'h8000_0000, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'h0,         "rem_ovf");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0,         5'd15, 1, 32'hFFFF_FFFF, "div_by0");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0,         5'd16, 1, 32'hFFFF_FFF9, "rem_by0");

    // Backpressure: response held for 10 cycles with resp_ready low.
    start_op(3'b000, 32'd12, 32'd11, 5'd21, "hold");
    wait_resp(n);
    check("hold_latency", n, 33);
    held_data = resp_data;
    held_tag  = resp_tag;
    check("hold_data", held_data, 32'd132);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== 32'd132 || resp_tag !== 5'd21 || req_ready) bad++;
    end
    check("hold_stable", bad, 0);
    resp_ready = 1'b1;
    check("hold_consume_req_ready", req_ready, 0);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("hold_idle_valid", resp_valid, 0);
    check("hold_idle_req_ready", req_ready, 1);

    // Flush on CALC cycle 10.
    start_op(3'b101, 32'd1000, 32'd3, 5'd22, "flush");
    repeat (10) @(negedge clk);
    flush = 1'b1;
    check("flush_req_ready_low", req_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_req_ready", req_ready, 1);
    check("flush_resp_valid", resp_valid, 0);
    expect_silence("flush");

    // Reset on CALC cycle 5.
    start_op(3'b000, 32'd9, 32'd9, 5'd23, "rstmid");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid_req_ready", req_ready, 0);
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_resp_data", resp_data, 0);
    check("rstmid_resp_tag", resp_tag, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_post_req_ready", req_ready, 1);
    expect_silence("rstmid");

    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd24, 33, 32'hFFFF_FFFF, "mulh_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have parameter TAGW, default 5, width of the destination-register tag.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port req_a  input  XLEN  rs1 operand.
REQ-009 SHALL have port req_b  input  XLEN  rs2 operand.
REQ-010 SHALL have port req_tag  input  TAGW  rd tag, returned unchanged.
REQ-011 SHALL have port flush  input  1  abort the current operation.
REQ-012 SHALL have port resp_valid  output  1  result present.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port resp_data  output  XLEN  result.
REQ-015 SHALL have port resp_tag  output  TAGW  tag of the result.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; req_ready = 1 only in IDLE with flush = 0.
REQ-017 SHALL accept a request on a rising edge with req_valid & req_ready, registering op, tag, operand magnitudes, result sign and a special-case flag.
REQ-018 SHALL, for a non-special request, go IDLE->CALC; CALC runs exactly XLEN cycles (one bit per cycle, shift-add multiply, restoring divide) and then goes to DONE.
REQ-019 SHALL assert resp_valid exactly XLEN+1 cycles after the accept edge for non-special requests.
REQ-020 SHALL treat divide-by-zero and signed overflow (DIV/REM with a = most-negative, b = -1) as special: go IDLE->DONE directly; resp_valid one cycle after the accept edge.
REQ-021 SHALL return, for divide-by-zero: DIV/DIVU all-ones, REM/REMU = a.
REQ-022 SHALL return, for signed overflow: DIV = a, REM = 0.
REQ-023 SHALL compute MUL as low XLEN bits of the product; MULH signed x signed, MULHSU signed a x unsigned b, MULHU unsigned x unsigned, each the upper XLEN bits of the 2*XLEN product.
REQ-024 SHALL truncate DIV toward zero; REM takes the sign of the dividend; DIVU/REMU are unsigned.
REQ-025 SHALL hold resp_valid, resp_data and resp_tag stable in DONE until resp_ready = 1; the DONE->IDLE transition occurs on that edge.
REQ-026 SHALL NOT accept a new request in the same cycle a response is consumed; the earliest next accept is one cycle after the DONE->IDLE edge.
REQ-027 SHALL, on flush = 1 in any state, go to IDLE on the next edge, discard the result, and emit no response; flush has priority over req_valid and resp_ready.
REQ-028 SHALL drive resp_data = 0 and resp_tag = 0 whenever resp_valid = 0.
REQ-029 SHALL size the iteration counter as clog2(XLEN)+1 bits, with no wrap inside an operation.

Reset
REQ-030 SHALL, while reset = 1, asynchronously force state IDLE, counter 0, resp_valid = 0, resp_data = 0, resp_tag = 0, req_ready = 0.
REQ-031 SHALL assert req_ready in the first cycle after reset deasserts.
REQ-032 SHALL, on reset asserted mid-CALC or in DONE, drop the operation with no response after release.

Verification
REQ-033 SHALL test MUL a=7, b=0xFFFFFFFD, tag=3 -> resp_data 0xFFFFFFEB, resp_tag 3, resp_valid exactly 33 cycles after accept.
REQ-034 SHALL test MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 SHALL test DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-036 SHALL test DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; each with resp_valid one cycle after accept.
REQ-037 SHALL test resp_ready held low 10 cycles in DONE -> resp_data and resp_tag stable and req_ready = 0 throughout; accept on release -> IDLE next cycle.
REQ-038 SHALL test flush on CALC cycle 10 -> no response and req_ready = 1 next cycle; reset on CALC cycle 5 -> all outputs 0 immediately and no response after release.
